mult_seq: RTL and testbench

MULT_SEQ -- requirements
Module: mult_seq

---
 rtl/mult_seq.sv | 181 ++++++++++++++++++
 tb/tb_mult_seq.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq.sv
// rtl/mult_seq.sv - sequencer that drives a shift-add multiplier through an s/done instruction handshake
// Optional feature macro MULT_SEQ_EARLY_EXIT_EN: stop iterating once the remaining multiplier bits are zero.

module mult_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        s,
  output logic [4:0]  op,
  output logic [15:0] in,
  input  logic        done,
  input  logic        lsb,
  output logic        busy,
  output logic        fin,
  output logic [6:0]  count
);

  localparam logic [4:0] OP_MOV0 = 5'b00000;
  localparam logic [4:0] OP_MOV1 = 5'b00100;
  localparam logic [4:0] OP_MOV2 = 5'b01000;
  localparam logic [4:0] OP_TST  = 5'b00011;
  localparam logic [4:0] OP_ADDC = 5'b11001;
  localparam logic [4:0] OP_SHR  = 5'b00001;
  localparam logic [4:0] OP_SHL  = 5'b00110;

  localparam logic [2:0] P_MOV0 = 3'd0;
  localparam logic [2:0] P_MOV1 = 3'd1;
  localparam logic [2:0] P_MOV2 = 3'd2;
  localparam logic [2:0] P_TST  = 3'd3;
  localparam logic [2:0] P_ADDC = 3'd4;
  localparam logic [2:0] P_SHR  = 3'd5;
  localparam logic [2:0] P_SHL  = 3'd6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    ACK   = 3'd2,
    WAIT  = 3'd3,
    NEXT  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  phase_q, phase_d, nxt_phase;
  logic [3:0]  iter_q, iter_d;
  logic [6:0]  count_q, count_d;
  logic [15:0] b_q, b_d;
  logic [4:0]  op_q, op_d;
  logic [15:0] in_q, in_d;
  logic        seq_last;
`ifdef MULT_SEQ_EARLY_EXIT_EN
  logic [15:0] shadow_q, shadow_d;
`endif

  function automatic logic [4:0] op_of(input logic [2:0] p);
    case (p)
      P_MOV0:  op_of = OP_MOV0;
      P_MOV1:  op_of = OP_MOV1;
      P_MOV2:  op_of = OP_MOV2;
      P_TST:   op_of = OP_TST;
      P_ADDC:  op_of = OP_ADDC;
      P_SHR:   op_of = OP_SHR;
      P_SHL:   op_of = OP_SHL;
      default: op_of = 5'b00000;
    endcase
  endfunction

  // Instruction after the one just completed; lsb is only meaningful after TST.
  always_comb begin
    nxt_phase = phase_q + 3'd1;
    seq_last  = 1'b0;
    case (phase_q)
      P_MOV2: begin
        nxt_phase = P_TST;
`ifdef MULT_SEQ_EARLY_EXIT_EN
        seq_last  = (shadow_q == 16'd0);
`endif
      end
      P_TST:  nxt_phase = lsb ? P_ADDC : P_SHR;
      P_SHL: begin
        nxt_phase = P_TST;
`ifdef MULT_SEQ_EARLY_EXIT_EN
        seq_last  = (iter_q == 4'd15) || (shadow_q[15:1] == 15'd0);
`else
        seq_last  = (iter_q == 4'd15);
`endif
      end
      default: nxt_phase = phase_q + 3'd1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    iter_d   = iter_q;
    count_d  = count_q;
    b_d      = b_q;
    op_d     = op_q;
    in_d     = in_q;
`ifdef MULT_SEQ_EARLY_EXIT_EN
    shadow_d = shadow_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = ISSUE;
          phase_d  = P_MOV0;
          iter_d   = 4'd0;
          count_d  = 7'd0;
          b_d      = b;
          op_d     = OP_MOV0;
          in_d     = a;
`ifdef MULT_SEQ_EARLY_EXIT_EN
          shadow_d = a;
`endif
        end
      end
      ISSUE: if (done) state_d = ACK;
      ACK:   if (!done) state_d = WAIT;
      WAIT: begin
        if (done) begin
          state_d = NEXT;
          count_d = count_q + 7'd1;
        end
      end
      NEXT: begin
`ifdef MULT_SEQ_EARLY_EXIT_EN
        if (phase_q == P_SHL) shadow_d = shadow_q >> 1;
`endif
        if (seq_last) begin
          state_d = IDLE;
        end else begin
          state_d = ISSUE;
          phase_d = nxt_phase;
          op_d    = op_of(nxt_phase);
          in_d    = (nxt_phase == P_MOV1) ? b_q : 16'd0;
          if (phase_q == P_SHL) iter_d = iter_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      phase_q  <= P_MOV0;
      iter_q   <= 4'd0;
      count_q  <= 7'd0;
      b_q      <= 16'd0;
      op_q     <= 5'd0;
      in_q     <= 16'd0;
`ifdef MULT_SEQ_EARLY_EXIT_EN
      shadow_q <= 16'd0;
`endif
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      iter_q   <= iter_d;
      count_q  <= count_d;
      b_q      <= b_d;
      op_q     <= op_d;
      in_q     <= in_d;
`ifdef MULT_SEQ_EARLY_EXIT_EN
      shadow_q <= shadow_d;
`endif
    end
  end

  // s in ISSUE follows done so a request is never raised at a busy multiplier.
  always_comb begin
    s     = (state_q == ACK) || ((state_q == ISSUE) && done);
    busy  = (state_q != IDLE);
    fin   = (state_q == NEXT) && seq_last;
    op    = op_q;
    in    = in_q;
    count = count_q;
  end

endmodule

// File: tb/tb_mult_seq.sv
// tb/tb_mult_seq.sv - self-checking bench for mult_seq with a behavioural multiplier model and product scoreboard

module tb_mult_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        s;
  logic [4:0]  op;
  logic [15:0] in;
  logic        done;
  logic        lsb;
  logic        busy;
  logic        fin;
  logic [6:0]  count;

  int errors = 0;
  int checks = 0;

  mult_seq dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .s(s), .op(op), .in(in), .done(done), .lsb(lsb),
    .busy(busy), .fin(fin), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural multiplier: accepts on s&&done, completes after a random delay.
  logic [15:0] r0 = 16'd0, r1 = 16'd0, r2 = 16'd0;
  logic        m_busy = 1'b0;
  logic [4:0]  m_op = 5'd0;
  logic [15:0] m_in = 16'd0;
  int          m_cnt = 0;
  int          max_delay = 0;
  int          tst_seen = 0;

  initial begin
    done = 1'b1;
    lsb  = 1'b0;
  end

  always @(posedge clk) begin
    if (!m_busy) begin
      if (s && done) begin
        m_op   <= op;
        m_in   <= in;
        m_cnt  <= $urandom_range(0, max_delay);
        m_busy <= 1'b1;
        done   <= 1'b0;
        if (op == 5'b00011) tst_seen <= tst_seen + 1;
      end
    end else if (m_cnt == 0) begin
      case (m_op)
        5'b00000: r0  <= m_in;
        5'b00100: r1  <= m_in;
        5'b01000: r2  <= m_in;
        5'b00011: lsb <= r0[0];
        5'b11001: r2  <= r2 + r1;
        5'b00001: r0  <= r0 >> 1;
        5'b00110: r1  <= r1 << 1;
        default: ;
      endcase
      done   <= 1'b1;
      m_busy <= 1'b0;
    end else begin
      m_cnt <= m_cnt - 1;
    end
  end

  // Handshake monitor: s must rise with done high; op/in must hold from s rise to WAIT exit.
  logic        s_prev = 1'b0;
  logic        trk = 1'b0;
  logic [4:0]  op_l = 5'd0;
  logic [15:0] in_l = 16'd0;
  int          viol_s = 0;
  int          viol_st = 0;

  always @(negedge clk) begin
    if (!reset) begin
      trk    <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      if (s && !s_prev && !done) viol_s <= viol_s + 1;
      if (s && !s_prev) begin
        trk  <= 1'b1;
        op_l <= op;
        in_l <= in;
      end else if (trk) begin
        if (op !== op_l || in !== in_l) viol_st <= viol_st + 1;
        if (!s && done) trk <= 1'b0;
      end
      s_prev <= s;
    end
  end

  logic [15:0] prod_q[$];
  int          cnt_q[$];

  function automatic int exp_count(input logic [15:0] av);
    int n;
    logic [15:0] sh;
    n  = 3;
    sh = av;
`ifdef MULT_SEQ_EARLY_EXIT_EN
    while (sh != 16'd0) begin
      n  = n + 3 + int'(sh[0]);
      sh = sh >> 1;
    end
`else
    for (int i = 0; i < 16; i++) begin
      n  = n + 3 + int'(sh[0]);
      sh = sh >> 1;
    end
`endif
    return n;
  endfunction

  // Called just after a negedge; start is presented for exactly one cycle.
  task automatic launch(input logic [15:0] aa, input logic [15:0] bb, input int ecnt);
    logic [31:0] full;
    full  = aa * bb;
    a     = aa;
    b     = bb;
    start = 1'b1;
    prod_q.push_back(full[15:0]);
    cnt_q.push_back(ecnt);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || count !== 7'd0) begin
      errors++;
      $display("FAIL launch: busy=%b count=%0d, required busy=1 count=0", busy, count);
    end
  endtask

  task automatic finish_check(input string name);
    int k;
    logic [15:0] ep;
    int ec;
    k = 0;
    while (!fin && k < 3000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL %s timeout: no fin within 3000 cycles", name);
      if (prod_q.size() > 0) begin
        ep = prod_q.pop_front();
        ec = cnt_q.pop_front();
      end
    end else begin
      ep = prod_q.pop_front();
      ec = cnt_q.pop_front();
      if (r2 !== ep) begin
        errors++;
        $display("FAIL %s product: got %h, required %h", name, r2, ep);
      end
      checks++;
      if (int'(count) != ec) begin
        errors++;
        $display("FAIL %s count: got %0d, required %0d", name, count, ec);
      end
      @(negedge clk);
      checks++;
      if (fin !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s after fin: fin=%b busy=%b, required 0 0", name, fin, busy);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    start = 1'b0;
    a = 16'd0;
    b = 16'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (s !== 1'b0 || op !== 5'd0 || in !== 16'd0 || busy !== 1'b0 || fin !== 1'b0 || count !== 7'd0) begin
      errors++;
      $display("FAIL reset: s=%b op=%h in=%h busy=%b fin=%b count=%0d, required all 0",
               s, op, in, busy, fin, count);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    int base;
    max_delay = 0;
`ifdef MULT_SEQ_EARLY_EXIT_EN
    launch(16'd6, 16'd7, 14);
`else
    launch(16'd6, 16'd7, 53);
`endif
    finish_check("a6b7");
    base = tst_seen;
`ifdef MULT_SEQ_EARLY_EXIT_EN
    launch(16'd0, 16'd123, 3);
`else
    launch(16'd0, 16'd123, 51);
`endif
    finish_check("a0");
    checks++;
`ifdef MULT_SEQ_EARLY_EXIT_EN
    if (tst_seen - base != 0) begin
      errors++;
      $display("FAIL a0 tst: got %0d TST, required 0", tst_seen - base);
    end
`else
    if (tst_seen - base != 16) begin
      errors++;
      $display("FAIL a0 tst: got %0d TST, required 16", tst_seen - base);
    end
`endif
    launch(16'hFFFF, 16'd1, 67);
    finish_check("aFFFF");
  endtask

  task automatic test_back_to_back;
    max_delay = 2;
    launch(16'h00A5, 16'h0103, exp_count(16'h00A5));
    finish_check("b2b_1");
    launch(16'h8001, 16'h7FFF, exp_count(16'h8001));
    finish_check("b2b_2");
  endtask

  task automatic test_ignore_start;
    int k;
    max_delay = 1;
    launch(16'h1234, 16'h0057, exp_count(16'h1234));
    k = 0;
    while (count != 7'd10 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (count != 7'd10) begin
      errors++;
      $display("FAIL ignore wait: count=%0d, required 10", count);
    end
    a     = 16'hAAAA;
    b     = 16'h5555;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_check("ignore_start");
  endtask

  task automatic test_reset_mid;
    int k;
    int fins;
    logic [15:0] dp;
    int dc;
    max_delay = 1;
    launch(16'hFFFF, 16'h0003, 67);
    k = 0;
    while (!(count == 7'd19 && s && !done) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!(count == 7'd19 && s && !done)) begin
      errors++;
      $display("FAIL reset_mid wait: count=%0d s=%b done=%b, required 19 1 0", count, s, done);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (s !== 1'b0 || busy !== 1'b0 || count !== 7'd0 || fin !== 1'b0 || op !== 5'd0 || in !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid: s=%b busy=%b count=%0d fin=%b op=%h in=%h, required all 0",
               s, busy, count, fin, op, in);
    end
    dp = prod_q.pop_back();
    dc = cnt_q.pop_back();
    fins = 0;
    repeat (3) begin
      @(negedge clk);
      if (fin) fins++;
    end
    reset = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (fin || busy) fins++;
    end
    checks++;
    if (fins != 0) begin
      errors++;
      $display("FAIL reset_mid resume: %0d cycles with fin/busy, required 0 (dropped %h/%0d)", fins, dp, dc);
    end
    launch(16'h0BCD, 16'h0321, exp_count(16'h0BCD));
    finish_check("after_reset");
  endtask

  task automatic test_random;
    logic [15:0] ra;
    logic [15:0] rb;
    max_delay = 5;
    for (int i = 0; i < 100; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 10 == 3) ra = ra & 16'h000F;
      launch(ra, rb, exp_count(ra));
      finish_check("random");
    end
    checks++;
    if (viol_s != 0) begin
      errors++;
      $display("FAIL s_rise: %0d rises with done=0, required 0", viol_s);
    end
    checks++;
    if (viol_st != 0) begin
      errors++;
      $display("FAIL op_in_stable: %0d changes during handshake, required 0", viol_st);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_ignore_start;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
